seg7_latched_to_bcd24: RTL and testbench
========================================

Name: seg7_latched_to_bcd24

Overview:
Receive-side decoder for the shared 7-seg bus with one-hot latch enables produced by the clock's display driver. Samples the bus on each latch strobe and maps each segment pattern back to BCD. Reassembles six-digit frames {Ht,Ho,Mt,Mo,St,So} and range-checks the time, then publishes it. Used as an on-chip loopback monitor and on the display board for readback and self-test.

Parameters:
SEG_ACTIVE_LOW, 1'b0, 1 = bus segments are inverted (common-anode); the block un-inverts before decoding.
LE_ACTIVE_HIGH, 1'b1, 0 = latch enables are active-low; the block inverts before use.
TIMEOUT, 8, number of consecutive cycles with no active LE after which lock is dropped (range 1..255).

Ports:
clk_ac  in  1  AC-tick clock, the same clock domain as the driver.
rst  in  1  synchronous, active-high reset.
seg7_bus  in  7  {a,b,c,d,e,f,g} segment bus.
le  in  6  latch enables; bit i = digit i, where 0 = Ht and 5 = So.
bcd24  out  24  last committed frame {Ht,Ho,Mt,Mo,St,So}.
frame_valid  out  1  one-cycle pulse when bcd24 is updated.
time_changed  out  1  one-cycle pulse, coincident with frame_valid, when the new bcd24 differs from the previous one.
locked  out  1  1 after the first committed frame; cleared by error or timeout.
seq_err  out  1  one-cycle pulse on a latch-sequence violation.
frame_err  out  1  one-cycle pulse when a complete frame is rejected.
err_count  out  8  saturating count of seq_err plus frame_err events.

Behaviour:
- Reset: bcd24=0, all pulse outputs=0, locked=0, err_count=0, FSM=HUNT, expect=0, idle counter=0, bad-frame flag=0.
- Inputs come from registers in the same domain, so there is no synchronizer. The bus is sampled in the same cycle that an LE bit is active.
- Normalization: leN is le, inverted when LE_ACTIVE_HIGH=0; segN is seg7_bus, inverted when SEG_ACTIVE_LOW=1.
- Decode table (segN to digit):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - Any other pattern, including dash 0000001, decodes to 4'hF and is marked invalid.
- Strobe classes per cycle: none (leN=0), single (exactly one bit set, index k), multi (two or more bits set).
- FSM HUNT:
  - single with k=0: capture digit 0, clear bad flag, expect=1, go to RECV.
  - Any other strobe: ignore. No seq_err is raised in HUNT.
- FSM RECV:
  - single with k=expect: capture digit k into the shadow register and OR invalid into the bad flag. expect increments; if k=5, commit and set expect=0.
  - single with k=0 and expect≠0: seq_err. Restart the frame with digit 0 captured and expect=1.
  - single with any other wrong k: seq_err, locked=0, go to HUNT.
  - multi: seq_err, locked=0, go to HUNT.
- Commit, evaluated on the So capture cycle using that cycle's digit:
  - The frame is good if the bad flag is clear, the So digit is valid, Ht≤2, (Ht=2 ⇒ Ho≤3), Mt≤5 and St≤5.
  - Good frame: on the next cycle bcd24 takes the shadow value, frame_valid=1, locked=1, and time_changed=(new≠old bcd24).
  - Bad frame: on the next cycle frame_err=1, bcd24 holds, locked=0, FSM stays in RECV with expect=0.
- Latency: frame_valid rises 1 cycle after the So strobe. With back-to-back strobes, frames commit every 6 cycles.
- Idle counter:
  - Cleared on any non-none strobe; otherwise increments, saturating.
  - When it reaches TIMEOUT: locked=0, FSM=HUNT, partial frame discarded. No error is counted.
- err_count: increments by 1 per cycle in which seq_err or frame_err is asserted (they never coincide) and saturates at 255.
- A mid-frame rst discards the shadow register and all state; bcd24 returns to 0.

Test Plan:
- Driver loopback sends Ht..So patterns 1101101,1111001,1011011,1111011,1011011,1111011 (23:59:59) on LE 0..5 over consecutive cycles -> the cycle after the So strobe, bcd24=24'h235959, frame_valid=1, time_changed=1, locked=1. Repeating the same frame -> frame_valid=1, time_changed=0.
- Start mid-frame by strobing LE3 then LE4 in HUNT -> no outputs change. The next LE0..5 sequence for 12:34:56 -> bcd24=24'h123456.
- While locked, apply LE0, LE1, then LE3 -> seq_err pulse, locked=0, err_count=1. A following full frame -> recovers and commits.
- Frame whose Mo slot carries dash 0000001 -> frame_err after So, bcd24 unchanged, err_count+1. Frame 24:00:00 -> frame_err from the Ht=2, Ho=4 range rule.
- SEG_ACTIVE_LOW=1 and LE_ACTIVE_HIGH=0 with inverted bus and LE versions of 07:05:09 -> bcd24=24'h070509. Strobe le=6'b000011 (multi, active-high config) -> seq_err.
- Hold LEs inactive for TIMEOUT=8 cycles while locked -> locked=0 at cycle 8. Assert rst mid-frame -> bcd24=0 and err_count=0 on the next cycle. Force 300 errors -> err_count=255.

Source files
------------

// File: rtl/seg7_latched_to_bcd24.sv
// Receive-side decoder for the shared 7-segment bus with one-hot latch enables.
// Samples the bus on each latch strobe and decodes each pattern back to BCD.
// Reassembles six-digit frames {Ht,Ho,Mt,Mo,St,So} and range-checks them.
// Publishes good frames, and tracks lock, sequencing errors and idle timeout.
module seg7_latched_to_bcd24 #(
    parameter logic        SEG_ACTIVE_LOW = 1'b0,
    parameter logic        LE_ACTIVE_HIGH = 1'b1,
    parameter int unsigned TIMEOUT        = 8
) (
    input  logic        clk_ac,
    input  logic        rst,
    input  logic [6:0]  seg7_bus,
    input  logic [5:0]  le,
    output logic [23:0] bcd24,
    output logic        frame_valid,
    output logic        time_changed,
    output logic        locked,
    output logic        seq_err,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    typedef enum logic {HUNT, RECV} state_t;

    state_t      state;
    logic [2:0]  exp_idx;
    logic [3:0]  shadow [0:4];
    logic        bad;
    logic [7:0]  idle_cnt;

    logic [5:0]  le_n;
    logic [6:0]  seg_n;
    logic [3:0]  digit;
    logic        dig_valid;
    logic        stb_none;
    logic        stb_single;
    logic        stb_multi;
    logic [2:0]  k;
    logic        frame_good;
    logic [23:0] new_frame;
    logic        timeout_hit;
    logic        seq_err_d;
    logic        frame_err_d;

    assign le_n  = LE_ACTIVE_HIGH ? le : ~le;
    assign seg_n = SEG_ACTIVE_LOW ? ~seg7_bus : seg7_bus;

    // Map a normalized segment pattern back to its BCD digit.
    always_comb begin
        dig_valid = 1'b1;
        case (seg_n)
            7'b1111110: digit = 4'd0;
            7'b0110000: digit = 4'd1;
            7'b1101101: digit = 4'd2;
            7'b1111001: digit = 4'd3;
            7'b0110011: digit = 4'd4;
            7'b1011011: digit = 4'd5;
            7'b1011111: digit = 4'd6;
            7'b1110000: digit = 4'd7;
            7'b1111111: digit = 4'd8;
            7'b1111011: digit = 4'd9;
            default: begin
                digit     = 4'hF;
                dig_valid = 1'b0;
            end
        endcase
    end

    // Classify the strobe and find the active digit index.
    always_comb begin
        stb_none   = (le_n == '0);
        stb_single = !stb_none && ((le_n & (le_n - 6'd1)) == '0);
        stb_multi  = !stb_none && !stb_single;
        k          = 3'd0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (le_n[i]) k = 3'(i);
        end
    end

    // Frame acceptance and error detection for the current strobe.
    always_comb begin
        new_frame   = {shadow[0], shadow[1], shadow[2], shadow[3], shadow[4], digit};
        frame_good  = !bad && dig_valid && (shadow[0] <= 4'd2) &&
                      !((shadow[0] == 4'd2) && (shadow[1] > 4'd3)) &&
                      (shadow[2] <= 4'd5) && (shadow[4] <= 4'd5);
        timeout_hit = (32'(idle_cnt) + 32'd1) >= TIMEOUT;
        seq_err_d   = (state == RECV) &&
                      (stb_multi || (stb_single && (k != exp_idx)));
        frame_err_d = (state == RECV) && stb_single && (k == exp_idx) &&
                      (k == 3'd5) && !frame_good;
    end

    // Receive FSM, shadow capture, commit, idle timeout and error counting.
    always_ff @(posedge clk_ac) begin
        if (rst) begin
            state        <= HUNT;
            exp_idx      <= '0;
            bad          <= 1'b0;
            idle_cnt     <= '0;
            bcd24        <= '0;
            frame_valid  <= 1'b0;
            time_changed <= 1'b0;
            locked       <= 1'b0;
            seq_err      <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
            for (int unsigned i = 0; i < 5; i++) shadow[i] <= '0;
        end else begin
            frame_valid  <= 1'b0;
            time_changed <= 1'b0;
            seq_err      <= seq_err_d;
            frame_err    <= frame_err_d;
            if ((seq_err_d || frame_err_d) && (err_count != '1))
                err_count <= err_count + 8'd1;

            if (stb_none) begin
                if (idle_cnt != '1) idle_cnt <= idle_cnt + 8'd1;
                if (timeout_hit) begin
                    locked  <= 1'b0;
                    state   <= HUNT;
                    exp_idx <= '0;
                end
            end else begin
                idle_cnt <= '0;
                case (state)
                    HUNT: begin
                        if (stb_single && (k == 3'd0)) begin
                            shadow[0] <= digit;
                            bad       <= ~dig_valid;
                            exp_idx   <= 3'd1;
                            state     <= RECV;
                        end
                    end
                    RECV: begin
                        if (stb_multi) begin
                            locked <= 1'b0;
                            state  <= HUNT;
                        end else if (k == exp_idx) begin
                            if (k == 3'd5) begin
                                // bad is cleared here so the next frame starts clean
                                exp_idx <= '0;
                                bad     <= 1'b0;
                                if (frame_good) begin
                                    bcd24        <= new_frame;
                                    frame_valid  <= 1'b1;
                                    time_changed <= (new_frame != bcd24);
                                    locked       <= 1'b1;
                                end else begin
                                    locked <= 1'b0;
                                end
                            end else begin
                                shadow[k] <= digit;
                                bad       <= (k == 3'd0) ? ~dig_valid : (bad | ~dig_valid);
                                exp_idx   <= exp_idx + 3'd1;
                            end
                        end else if (k == 3'd0) begin
                            shadow[0] <= digit;
                            bad       <= ~dig_valid;
                            exp_idx   <= 3'd1;
                        end else begin
                            locked <= 1'b0;
                            state  <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_latched_to_bcd24.sv
// Scoreboard bench for seg7_latched_to_bcd24: a frame-level reference model
// predicts every output pulse; monitors pop and compare for two instances
// (normal polarity, and inverted bus / active-low LE fed the inverted stimulus).
module tb_seg7_latched_to_bcd24;

    localparam int unsigned TO = 8;

    logic clk_ac = 1'b0;
    always #5 clk_ac = ~clk_ac;

    logic       rst;
    logic [6:0] seg;
    logic [5:0] le;

    logic [23:0] a_bcd, b_bcd;
    logic        a_fv, a_tc, a_lk, a_se, a_fe;
    logic        b_fv, b_tc, b_lk, b_se, b_fe;
    logic [7:0]  a_ec, b_ec;

    seg7_latched_to_bcd24 #(.SEG_ACTIVE_LOW(1'b0), .LE_ACTIVE_HIGH(1'b1), .TIMEOUT(TO)) u_a (
        .clk_ac(clk_ac), .rst(rst), .seg7_bus(seg), .le(le),
        .bcd24(a_bcd), .frame_valid(a_fv), .time_changed(a_tc), .locked(a_lk),
        .seq_err(a_se), .frame_err(a_fe), .err_count(a_ec));

    seg7_latched_to_bcd24 #(.SEG_ACTIVE_LOW(1'b1), .LE_ACTIVE_HIGH(1'b0), .TIMEOUT(TO)) u_b (
        .clk_ac(clk_ac), .rst(rst), .seg7_bus(~seg), .le(~le),
        .bcd24(b_bcd), .frame_valid(b_fv), .time_changed(b_tc), .locked(b_lk),
        .seq_err(b_se), .frame_err(b_fe), .err_count(b_ec));

    typedef struct packed {
        logic [2:0]  kind;   // {frame_valid, frame_err, seq_err}
        logic [23:0] bcd;
        logic        tc;
        logic        lk;
        logic [7:0]  ec;
    } evt_t;

    evt_t qa[$];
    evt_t qb[$];
    int tests = 0;
    int fails = 0;

    logic [6:0] pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // reference model state
    bit          m_hunt;
    int          m_next;
    int          m_dig [6];
    bit          m_bad;
    int          m_idle;
    logic [23:0] m_bcd;
    bit          m_locked;
    int          m_err;

    function automatic int decode_m(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pats[i] == s) return i;
        return 15;
    endfunction

    task automatic model_reset();
        m_hunt = 1; m_next = 0; m_bad = 0; m_idle = 0;
        m_bcd = '0; m_locked = 0; m_err = 0;
        for (int i = 0; i < 6; i++) m_dig[i] = 0;
    endtask

    task automatic push(input evt_t e);
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic model_err(input bit is_frame);
        evt_t e;
        m_err  = (m_err < 255) ? m_err + 1 : 255;
        e.kind = is_frame ? 3'b010 : 3'b001;
        e.bcd  = m_bcd;
        e.tc   = 1'b0;
        e.lk   = m_locked;
        e.ec   = 8'(m_err);
        push(e);
    endtask

    task automatic model_step(input logic [5:0] l, input logic [6:0] s);
        int n, k, d;
        bit good;
        logic [23:0] nb;
        evt_t e;
        n = $countones(l);
        if (n == 0) begin
            if (m_idle < 255) m_idle++;
            if (m_idle >= int'(TO)) begin m_locked = 0; m_hunt = 1; end
            return;
        end
        m_idle = 0;
        d = decode_m(s);
        k = 0;
        for (int i = 0; i < 6; i++) if (l[i]) k = i;
        if (n > 1) begin
            if (!m_hunt) begin m_locked = 0; m_hunt = 1; model_err(0); end
            return;
        end
        if (m_hunt) begin
            if (k == 0) begin m_dig[0] = d; m_bad = (d > 9); m_next = 1; m_hunt = 0; end
            return;
        end
        if (k == m_next) begin
            m_dig[k] = d;
            m_bad = (k == 0) ? (d > 9) : (m_bad || d > 9);
            if (k < 5) m_next++;
            else begin
                m_next = 0;
                good = !m_bad && m_dig[0] <= 2 && !(m_dig[0] == 2 && m_dig[1] > 3) &&
                       m_dig[2] <= 5 && m_dig[4] <= 5;
                if (good) begin
                    nb = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]),
                          4'(m_dig[3]), 4'(m_dig[4]), 4'(m_dig[5])};
                    e.kind = 3'b100; e.tc = (nb != m_bcd);
                    m_bcd = nb; m_locked = 1;
                    e.bcd = m_bcd; e.lk = 1'b1; e.ec = 8'(m_err);
                    push(e);
                end else begin
                    m_locked = 0;
                    model_err(1);
                end
            end
        end else if (k == 0) begin
            m_dig[0] = d; m_bad = (d > 9); m_next = 1;
            model_err(0);
        end else begin
            m_locked = 0; m_hunt = 1;
            model_err(0);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_evt(input string tag, input evt_t act, input evt_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL evt_%s: got kind=%b bcd=%h tc=%b lk=%b ec=%0d, expected kind=%b bcd=%h tc=%b lk=%b ec=%0d",
                     tag, act.kind, act.bcd, act.tc, act.lk, act.ec,
                     exp.kind, exp.bcd, exp.tc, exp.lk, exp.ec);
        end
    endtask

    // monitor: pop an expected event whenever an instance shows any pulse
    initial begin
        evt_t act, exp;
        forever begin
            @(negedge clk_ac);
            if (a_fv || a_fe || a_se || a_tc) begin
                act = '{kind: {a_fv, a_fe, a_se}, bcd: a_bcd, tc: a_tc, lk: a_lk, ec: a_ec};
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_A: kind=%b bcd=%h with nothing expected", act.kind, act.bcd);
                end else begin
                    exp = qa.pop_front();
                    cmp_evt("A", act, exp);
                end
            end
            if (b_fv || b_fe || b_se || b_tc) begin
                act = '{kind: {b_fv, b_fe, b_se}, bcd: b_bcd, tc: b_tc, lk: b_lk, ec: b_ec};
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_B: kind=%b bcd=%h with nothing expected", act.kind, act.bcd);
                end else begin
                    exp = qb.pop_front();
                    cmp_evt("B", act, exp);
                end
            end
        end
    end

    task automatic cyc(input logic [5:0] l, input logic [6:0] s);
        le = l; seg = s;
        model_step(l, s);
        @(posedge clk_ac); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(6'd0, 7'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1; le = '0; seg = '0;
        model_reset();
        @(posedge clk_ac); #1;
        rst = 1'b0;
    endtask

    // nibble 4'hF is sent as a dash
    task automatic send_bcd(input logic [23:0] v);
        logic [3:0] d;
        for (int i = 0; i < 6; i++) begin
            d = v[20 - 4*i +: 4];
            cyc(6'(1 << i), (d <= 4'd9) ? pats[int'(d)] : 7'b0000001);
        end
    endtask

    function automatic logic [23:0] rand_time(input bit legal);
        logic [3:0] h1, h0;
        if (!legal)
            return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        h1 = 4'($urandom_range(0, 2));
        h0 = 4'((h1 == 4'd2) ? $urandom_range(0, 3) : $urandom_range(0, 9));
        return {h1, h0, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        logic [5:0] ml;
        rst = 1'b0; le = '0; seg = '0;
        model_reset();
        @(posedge clk_ac); #1;
        do_reset();
        chk("reset_bcd_a", 32'(a_bcd), 0);
        chk("reset_locked_a", 32'(a_lk), 0);
        chk("reset_errc_a", 32'(a_ec), 0);
        chk("reset_pulses_a", 32'({a_fv, a_tc, a_se, a_fe}), 0);
        chk("reset_bcd_b", 32'(b_bcd), 0);
        chk("reset_pulses_b", 32'({b_fv, b_tc, b_se, b_fe, b_lk}), 0);

        // mid-frame start in HUNT is ignored
        cyc(6'b001000, pats[3]);
        cyc(6'b010000, pats[4]);
        chk("hunt_ignore_bcd", 32'(a_bcd), 0);
        chk("hunt_ignore_lk", 32'(a_lk), 0);
        send_bcd(24'h123456);
        chk("commit_123456", 32'(a_bcd), 32'h123456);

        send_bcd(24'h235959);
        chk("commit_235959", 32'(a_bcd), 32'h235959);
        chk("tc_first", 32'({a_fv, a_tc, a_lk}), 32'b111);
        send_bcd(24'h235959);
        chk("tc_repeat", 32'({a_fv, a_tc}), 32'b10);

        // wrong index while locked
        cyc(6'b000001, pats[1]);
        cyc(6'b000010, pats[2]);
        cyc(6'b001000, pats[3]);
        chk("seqerr_pulse", 32'({a_se, a_lk}), 32'b10);
        chk("seqerr_count", 32'(a_ec), 1);
        send_bcd(24'h010203);
        chk("recover", 32'({a_lk, a_bcd}), {7'd0, 1'b1, 24'h010203});

        send_bcd(24'h123F45);
        chk("dash_frame_err", 32'({a_fe, a_lk}), 32'b10);
        chk("dash_bcd_hold", 32'(a_bcd), 32'h010203);
        chk("dash_count", 32'(a_ec), 2);
        send_bcd(24'h240000);
        chk("range_frame_err", 32'(a_fe), 1);
        chk("range_count", 32'(a_ec), 3);

        send_bcd(24'h070509);
        chk("inv_cfg_bcd", 32'(b_bcd), 32'h070509);
        chk("inv_cfg_fv", 32'({b_fv, b_lk}), 32'b11);

        cyc(6'b000001, pats[0]);
        cyc(6'b000011, pats[1]);
        chk("multi_seqerr_a", 32'(a_se), 1);
        chk("multi_seqerr_b", 32'(b_se), 1);

        // idle timeout
        send_bcd(24'h000000);
        chk("pre_timeout_lk", 32'(a_lk), 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(6'd0, 7'($urandom));
            chk($sformatf("timeout_lk_%0d", i), 32'(a_lk), 32'(i < 8));
            chk($sformatf("timeout_lk_model_%0d", i), 32'(b_lk), 32'(m_locked));
        end

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0, 1:    send_bcd(rand_time(1'b1));
                2:       send_bcd(rand_time(1'b0));
                3:       cyc(6'(1 << $urandom_range(0, 5)), pats[$urandom_range(0, 9)]);
                4:       cyc(6'(1 << $urandom_range(0, 5)), 7'($urandom));
                5: begin
                    ml = 6'($urandom);
                    while ($countones(ml) < 2) ml = 6'($urandom);
                    cyc(ml, pats[$urandom_range(0, 9)]);
                end
                default: idle($urandom_range(1, 10));
            endcase
            chk($sformatf("rand_lk_%0d", it), 32'(a_lk), 32'(m_locked));
            chk($sformatf("rand_bcd_%0d", it), 32'(b_bcd), 32'(m_bcd));
        end

        // reset mid-frame
        send_bcd(24'h115511);
        cyc(6'b000001, pats[1]);
        cyc(6'b000010, pats[2]);
        do_reset();
        chk("midrst_bcd", 32'(a_bcd), 0);
        chk("midrst_errc", 32'(a_ec), 0);
        chk("midrst_lk", 32'(a_lk), 0);

        // saturate the error counter with repeated Ht restarts
        cyc(6'b000001, pats[2]);
        repeat (300) cyc(6'b000001, pats[2]);
        chk("errc_sat_a", 32'(a_ec), 255);
        chk("errc_sat_b", 32'(b_ec), 255);

        idle(4);
        chk("drain_qa", 32'(qa.size()), 0);
        chk("drain_qb", 32'(qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
